// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - recovers hex digits from a multiplexed 7-segment scan bus
module seg_scan_decoder #(
  parameter int DIGITS     = 4,
  parameter int STABLE_CNT = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sample_en,
  input  logic [DIGITS-1:0]     dig_sel,
  input  logic [7:0]            seg_in,
  output logic [4*DIGITS-1:0]   hex_out,
  output logic [DIGITS-1:0]     dp_out,
  output logic [DIGITS-1:0]     digit_valid,
  output logic                  frame_valid,
  output logic                  code_err,
  output logic                  sel_err
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [3:0] STB = 4'(STABLE_CNT);

  // stage 1 capture registers
  logic [7:0]          r_seg;
  logic [DIGITS-1:0]   r_sel;
  logic                r_sample_v;

  // per-digit stability tracking
  logic [6:0]          r_cand [DIGITS];
  logic [3:0]          r_cnt  [DIGITS];
  logic [DIGITS-1:0]   r_seen;

  // registered outputs
  logic [4*DIGITS-1:0] r_hex;
  logic [DIGITS-1:0]   r_dp;
  logic [DIGITS-1:0]   r_dv;
  logic                r_fv;
  logic                r_ce;
  logic                r_se;

  logic                w_onehot;
  logic [IW-1:0]       w_idx;
  logic [6:0]          w_cand;
  logic [3:0]          w_cnt;
  logic                w_match;
  logic [3:0]          w_cnt_nx;
  logic                w_accept;
  logic                w_legal;
  logic [3:0]          w_val;
  logic [DIGITS-1:0]   w_seen_nx;

  assign hex_out     = r_hex;
  assign dp_out      = r_dp;
  assign digit_valid = r_dv;
  assign frame_valid = r_fv;
  assign code_err    = r_ce;
  assign sel_err     = r_se;

  // pick out which digit the captured select addresses (valid only when one-hot)
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_sel[i]) w_idx = IW'(i);
    end
  end

  assign w_onehot  = (r_sel != '0) && ((r_sel & (r_sel - 1'b1)) == '0);
  assign w_cand    = r_cand[w_idx];
  assign w_cnt     = r_cnt[w_idx];
  assign w_match   = (w_cand == r_seg[6:0]);
  assign w_cnt_nx  = w_match ? ((w_cnt == STB) ? w_cnt : w_cnt + 4'd1) : 4'd1;
  // a fresh pattern only accepts immediately when one sample is enough
  assign w_accept  = (w_cnt_nx == STB) && (!w_match || (w_cnt != STB));
  assign w_seen_nx = r_seen | r_sel;

  // segment pattern to hex value; anything outside the 16 glyphs is illegal
  always_comb begin
    w_legal = 1'b1;
    w_val   = 4'h0;
    case (r_seg[6:0])
      7'h3F: w_val = 4'h0;
      7'h06: w_val = 4'h1;
      7'h5B: w_val = 4'h2;
      7'h4F: w_val = 4'h3;
      7'h66: w_val = 4'h4;
      7'h6D: w_val = 4'h5;
      7'h7D: w_val = 4'h6;
      7'h07: w_val = 4'h7;
      7'h7F: w_val = 4'h8;
      7'h6F: w_val = 4'h9;
      7'h77: w_val = 4'hA;
      7'h7C: w_val = 4'hB;
      7'h39: w_val = 4'hC;
      7'h5E: w_val = 4'hD;
      7'h79: w_val = 4'hE;
      7'h71: w_val = 4'hF;
      default: w_legal = 1'b0;
    endcase
  end

  // capture the bus on sample strobes; capture regs hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg      <= '0;
      r_sel      <= '0;
      r_sample_v <= 1'b0;
    end else begin
      r_sample_v <= sample_en;
      if (sample_en) begin
        r_seg <= seg_in;
        r_sel <= dig_sel;
      end
    end
  end

  // evaluate the captured sample: stability count, acceptance, frame tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DIGITS; i++) begin
        r_cand[i] <= '0;
        r_cnt[i]  <= '0;
      end
      r_seen <= '0;
      r_hex  <= '0;
      r_dp   <= '0;
      r_dv   <= '0;
      r_fv   <= 1'b0;
      r_ce   <= 1'b0;
      r_se   <= 1'b0;
    end else begin
      r_fv <= 1'b0;
      r_ce <= 1'b0;
      r_se <= 1'b0;
      if (r_sample_v) begin
        if (!w_onehot) begin
          r_se <= 1'b1;
        end else begin
          r_cand[w_idx] <= r_seg[6:0];
          r_cnt[w_idx]  <= w_cnt_nx;
          if (w_accept) begin
            if (w_legal) begin
              r_hex[{w_idx, 2'b00} +: 4] <= w_val;
              r_dp[w_idx] <= r_seg[7];
              r_dv[w_idx] <= 1'b1;
              if (&w_seen_nx) begin
                r_fv   <= 1'b1;
                r_seen <= '0;
              end else begin
                r_seen <= w_seen_nx;
              end
            end else begin
              r_ce        <= 1'b1;
              r_dv[w_idx] <= 1'b0;
            end
          end
        end
      end
    end
  end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receive side of the Dynamo 7-segment path: samples a time-multiplexed digit-select/segment bus, as driven by the segment encoder and scan logic, and recovers the 4-bit hex value of each digit.
- Used as an on-chip loopback monitor and a bench checker.
- Requires each digit pattern to be stable for several scans before accepting it.
- Flags illegal segment patterns and malformed digit selects, and pulses when a full frame of digits has been refreshed.

Parameters:
- DIGITS, 4, number of multiplexed digits (1..8).
- STABLE_CNT, 3, consecutive identical samples of one digit required before acceptance (1..15).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sample_en  input  1  sample strobe; the bus is sampled only in cycles where it is 1.
- dig_sel  input  DIGITS  one-hot active-high digit select; bit i = digit i.
- seg_in  input  8  segment lines, bit0=a .. bit6=g, bit7=dp; active-high.
- hex_out  output  4*DIGITS  decoded values; digit i in bits [4i+3:4i].
- dp_out  output  DIGITS  accepted decimal-point state per digit.
- digit_valid  output  DIGITS  1 = digit i holds an accepted legal code.
- frame_valid  output  1  one-cycle pulse when every digit has been accepted since the last pulse.
- code_err  output  1  one-cycle pulse: an illegal pattern became stable.
- sel_err  output  1  one-cycle pulse: a sampled dig_sel was not one-hot.

Behaviour:
- Reset (async assert, sync-safe release):
  - hex_out, dp_out, digit_valid, frame_valid, code_err and sel_err are all 0.
  - Per-digit candidate registers and counters are 0.
  - The frame seen-mask is 0.
- Stage 1 (capture): in a cycle with sample_en=1, register seg_in and dig_sel and set an internal sample_v.
  - sample_en=0 leaves all state unchanged.
- Stage 2 (evaluate, cycle after capture), when sample_v=1:
  - dig_sel zero or multi-hot: sel_err=1 for one cycle; no digit state changes.
  - Otherwise, for the selected digit i, compare seg[6:0] with candidate[i].
    - Equal: cnt[i] increments, saturating at STABLE_CNT.
    - Different: candidate[i]=seg[6:0] and cnt[i]=1.
    - dp is tracked separately and does not participate in the compare.
  - Acceptance event for digit i: cnt[i] transitions to STABLE_CNT in this evaluation, including STABLE_CNT=1 on the first sample. Further matching samples at saturation cause no new event.
- Decode table for seg[6:0] -> value:
  - 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7
  - 7F->8, 6F->9, 77->A, 7C->B, 39->C, 5E->D, 79->E, 71->F
  - All other patterns are illegal.
- On an acceptance event:
  - Legal pattern: hex_out[i] = value; dp_out[i] = seg bit7 of the accepting sample; digit_valid[i]=1; seen-mask bit i set.
  - Illegal pattern: code_err=1 for one cycle; digit_valid[i]=0; hex_out[i] and dp_out[i] hold their previous values; seen-mask bit i is not set.
- Latency: sample_en cycle k -> outputs change at the clk edge ending cycle k+1 (i.e., visible in cycle k+2).
- frame_valid:
  - Pulses 1 cycle in the cycle its update is registered, when the seen-mask becomes all-ones.
  - The mask clears in the same update.
  - Re-accepting an already-seen digit does not advance the frame.
- Simultaneous events:
  - sel_err and code_err are mutually exclusive, since only one sample is evaluated per cycle.
  - frame_valid and a legal acceptance coincide by construction.
- sample_en back-to-back on every clk is supported at full rate; no backpressure.
- Reset asserted mid-scan: all counters, candidates and the mask clear immediately; the first post-reset sample starts a fresh count.
- No combinational path from inputs to outputs.

Test Plan:
- Reset: hold rst_n=0 while driving traffic -> all outputs 0. Release, then DIGITS=4, STABLE_CNT=3: scan digits 0..3 with 3F,06,5B,4F (3 rounds, sample_en=1) -> hex_out=16'h3210, digit_valid=4'hF, one frame_valid pulse two cycles after the 12th sample, code_err=0.
- Stability: digit 2 samples 66,66,7D,7D,7D -> hex_out[11:8] is unchanged until the 5th sample, then becomes 6; it never takes value 4.
- Illegal code: digit 1 three samples of 7'h00 after a valid 06 -> one code_err pulse, digit_valid[1]=0, hex_out[7:4] stays 1; a fourth 00 sample gives no further pulse.
- Bad select: dig_sel=4'b0000, then 4'b0110 with seg=3F -> two sel_err pulses, no counter or output change. Then sample_en=0 with bus toggling -> no state change.
- DP: digit 3 three samples of 8'hF1 -> hex_out[15:12]=F, dp_out[3]=1. A following 8'h71 sample does not reset the count and does not update dp_out.
- Async reset mid-frame: after digits 0,1 are accepted, pulse rst_n low between clk edges -> outputs clear immediately. Digits 2,3 alone post-reset give no frame_valid; all four must be accepted again.
